updown_counter: RTL and testbench
=================================

UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter register width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter MODULUS, default 16, meaning count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 The block SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port en  input  1  count enable.
REQ-006 The block SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 The block SHALL have port d  input  WIDTH  parallel load value.
REQ-009 The block SHALL have port refresh  input  WIDTH  synchronous per-bit set mask.
REQ-010 The block SHALL have port q  output  WIDTH  current count, registered.
REQ-011 The block SHALL have port tc  output  1  terminal count, combinational.
REQ-012 The block SHALL have port wrap  output  1  one-cycle registered wrap pulse.

Function
REQ-013 Per rising clk edge, the block SHALL select the next q by priority load > refresh != 0 > en > hold.
REQ-014 With load=1, q SHALL become d; if d >= MODULUS, q SHALL become MODULUS-1.
REQ-015 With load=0 and refresh != 0, q SHALL become q | refresh, clamped to MODULUS-1 if >= MODULUS; no count occurs that cycle.
REQ-016 With load=0, refresh=0, en=1, up=1: q SHALL become q+1, or 0 when q == MODULUS-1.
REQ-017 With load=0, refresh=0, en=1, up=0: q SHALL become q-1, or MODULUS-1 when q == 0.
REQ-018 With load=0, refresh=0, en=0, q SHALL hold.
REQ-019 All arithmetic SHALL be modulo MODULUS; q SHALL never hold a value >= MODULUS after any edge.
REQ-020 tc SHALL be 1 iff en=1 and ((up=1 and q == MODULUS-1) or (up=0 and q == 0)), independent of load/refresh.
REQ-021 wrap SHALL be 1 for exactly the cycle after an edge on which REQ-016/REQ-017 wrap-around was taken, else 0.
REQ-022 Load or refresh at a terminal value SHALL suppress wrap even if tc=1 that cycle.
REQ-023 Direction changes SHALL take effect on the same edge, with no extra latency.
REQ-024 Latency from any control input to q SHALL be exactly one clock edge.
REQ-025 With MODULUS == 2**WIDTH, the clamp SHALL be inert and counting SHALL be plain binary wrap.

Reset
REQ-026 nrst=0 SHALL immediately force q=0 and wrap=0, regardless of clk.
REQ-027 While nrst=0, all inputs SHALL be ignored; tc SHALL still follow REQ-020 on q=0.
REQ-028 On the first rising edge after nrst deasserts, the block SHALL apply normal REQ-013 operation.
REQ-029 nrst asserted mid-count SHALL clear any pending wrap pulse in the same instant.

Verification (WIDTH=4, MODULUS=10)
REQ-030 Reset, then en=1, up=1 for 12 edges -> q SHALL go 1..9,0,1,2; tc=1 at q=9; wrap=1 only in the cycle q=0.
REQ-031 From q=0, en=1, up=0 -> q SHALL go 9 with wrap=1, then 8; tc=1 while q=0.
REQ-032 load=1, d=13 -> q SHALL be 9; load=1, d=5 with en=1, refresh=4'b1000 -> q SHALL be 5.
REQ-033 At q=4, refresh=4'b0001, en=1 -> q SHALL be 5, not 6; at q=2, refresh=4'b1000 -> q SHALL be 9 (clamped from 10).
REQ-034 At q=9, up=1, en=1, load=1, d=3 -> q SHALL be 3 and wrap SHALL be 0 next cycle.
REQ-035 nrst pulsed low between edges while q=7 -> q SHALL be 0 and wrap 0 at once; counting SHALL resume from 0 after release.

Source files
------------

// File: rtl/updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, per-bit set mask and wrap pulse.
// Latency: any control input reaches q one clock edge later; tc is combinational.
// Backpressure: none, the counter accepts controls every cycle.
module updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] refresh,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    // One extra bit so MODULUS == 2**WIDTH compares correctly and never clamps.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        if ({1'b0, v} >= MOD_EXT) begin
            return MAX_VAL;
        end
        return v;
    endfunction

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    assign tc = en && ((up && (q == MAX_VAL)) || (!up && (q == '0)));

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = clamp(d);
        end else if (|refresh) begin
            q_nxt = clamp(q | refresh);
        end else if (en) begin
            if (up) begin
                if (q == MAX_VAL) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    q_nxt    = MAX_VAL;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter at WIDTH=4, MODULUS=10.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en, up, load;
    logic [3:0] d, refresh;
    logic [3:0] q;
    logic       tc, wrap;

    int checks = 0;
    int errors = 0;

    updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .nrst(nrst), .en(en), .up(up), .load(load),
        .d(d), .refresh(refresh), .q(q), .tc(tc), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [3:0] d;
        logic [3:0] refresh;
        logic       en;
        logic       up;
        logic       tc;    // expected before the edge
        logic [3:0] q;     // expected after the edge
        logic       wrap;  // expected after the edge
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       wrap;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic ld, logic [3:0] dv, logic [3:0] rf, logic e, logic u,
                                logic t, logic [3:0] qe, logic w);
        vec_t v;
        v.load = ld; v.d = dv; v.refresh = rf; v.en = e; v.up = u;
        v.tc = t; v.q = qe; v.wrap = w;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector, check tc, push the post-edge expectation, then pop it after the edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        load = v.load; d = v.d; refresh = v.refresh; en = v.en; up = v.up;
        #1;
        check($sformatf("tc[%0d]", idx), int'(tc), int'(v.tc));
        sb.push_back('{q: v.q, wrap: v.wrap, idx: idx});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check($sformatf("q[%0d]", e.idx), int'(q), int'(e.q));
            check($sformatf("wrap[%0d]", e.idx), int'(wrap), int'(e.wrap));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = '0; refresh = '0;

        // Reset state and tc behaviour while held in reset.
        #3;
        check("rst_q", int'(q), 0);
        check("rst_wrap", int'(wrap), 0);
        en = 1'b1; up = 1'b0; #1;
        check("rst_tc_down", int'(tc), 1);
        up = 1'b1; #1;
        check("rst_tc_up", int'(tc), 0);
        load = 1'b1; d = 4'd5; refresh = 4'd3;
        @(posedge clk); #1;
        check("rst_ignores_inputs_q", int'(q), 0);
        check("rst_ignores_inputs_wrap", int'(wrap), 0);
        load = 1'b0; d = '0; refresh = '0; en = 1'b0;
        nrst = 1'b1;

        //               ld  d      rf       en    up    tc    q      wrap
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0, 4'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'(i + 1), 1'b0));
        vecs.push_back(mk(0, 4'd0,  4'b0000, 1, 1, 1, 4'd0, 1));  // 9 -> 0 wraps
        vecs.push_back(mk(0, 4'd0,  4'b0000, 1, 1, 0, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0,  4'b0000, 1, 1, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'd0,  4'b0000, 0, 1, 0, 4'd0, 0));
        vecs.push_back(mk(0, 4'd0,  4'b0000, 1, 0, 1, 4'd9, 1));  // 0 -> 9 down-wrap
        vecs.push_back(mk(0, 4'd0,  4'b0000, 1, 0, 0, 4'd8, 0));
        vecs.push_back(mk(1, 4'd13, 4'b0000, 0, 1, 0, 4'd9, 0));  // load clamps
        vecs.push_back(mk(1, 4'd5,  4'b1000, 1, 1, 1, 4'd5, 0));  // load beats refresh/en
        vecs.push_back(mk(1, 4'd4,  4'b0000, 0, 1, 0, 4'd4, 0));
        vecs.push_back(mk(0, 4'd0,  4'b0001, 1, 1, 0, 4'd5, 0));  // refresh, no count
        vecs.push_back(mk(1, 4'd2,  4'b0000, 0, 1, 0, 4'd2, 0));
        vecs.push_back(mk(0, 4'd0,  4'b1000, 1, 0, 0, 4'd9, 0));  // 10 clamps to 9
        vecs.push_back(mk(1, 4'd3,  4'b0000, 1, 1, 1, 4'd3, 0));  // load at terminal
        vecs.push_back(mk(0, 4'd0,  4'b0000, 0, 1, 0, 4'd3, 0));  // hold
        vecs.push_back(mk(0, 4'd0,  4'b0000, 1, 1, 0, 4'd4, 0));
        vecs.push_back(mk(0, 4'd0,  4'b0000, 1, 0, 0, 4'd3, 0));  // direction flip
        vecs.push_back(mk(1, 4'd0,  4'b0000, 0, 0, 0, 4'd0, 0));
        vecs.push_back(mk(0, 4'd0,  4'b0001, 1, 0, 1, 4'd1, 0));  // refresh at terminal
        vecs.push_back(mk(1, 4'd15, 4'b0000, 0, 0, 0, 4'd9, 0));
        vecs.push_back(mk(0, 4'd0,  4'b0110, 0, 0, 0, 4'd9, 0));  // 15 clamps to 9
        vecs.push_back(mk(1, 4'd10, 4'b0000, 0, 0, 0, 4'd9, 0));
        vecs.push_back(mk(1, 4'd7,  4'b0000, 0, 1, 0, 4'd7, 0));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], i);

        // Async reset between edges at q=7, then resume counting from 0.
        @(negedge clk);
        nrst = 1'b0; #1;
        check("mid_rst_q", int'(q), 0);
        check("mid_rst_wrap", int'(wrap), 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        step(mk(0, 4'd0, 4'b0000, 1, 1, 0, 4'd1, 0), 100);
        step(mk(0, 4'd0, 4'b0000, 1, 1, 0, 4'd2, 0), 101);

        // Reset must kill a pending wrap pulse immediately.
        step(mk(1, 4'd9, 4'b0000, 0, 1, 0, 4'd9, 0), 102);
        step(mk(0, 4'd0, 4'b0000, 1, 1, 1, 4'd0, 1), 103);
        @(negedge clk);
        nrst = 1'b0; #1;
        check("wrap_cleared_by_rst", int'(wrap), 0);
        check("q_after_wrap_rst", int'(q), 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        step(mk(0, 4'd0, 4'b0000, 1, 0, 1, 4'd9, 1), 104);
        step(mk(0, 4'd0, 4'b0000, 0, 0, 0, 4'd9, 0), 105);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
